// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with two read ports and two write
// ports (B has priority on address collisions), optional write-to-read bypass,
// optional hardwired-zero register 0, and a sequential sweep-clear engine that
// zeroes one entry per cycle without needing a reset.
//
// Ports:
//   clock, reset         clock and asynchronous active-low reset
//   rd_addr1/rd_data1    read port 1 (combinational data)
//   rd_addr2/rd_data2    read port 2 (combinational data)
//   we_a/wr_addr_a/wr_data_a  write port A (ALU result)
//   we_b/wr_addr_b/wr_data_b  write port B (memory load, priority)
//   clr_req              start a sweep clear (accepted in IDLE only)
//   clr_busy             high for the NUM_REGS cycles of a sweep
//   zero_wr_err          one-cycle pulse after a rejected write to register 0
module regfile_mp #(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned BYPASS   = 1,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     rd_addr1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              we_a,
  input  logic [AW-1:0]     wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              we_b,
  input  logic [AW-1:0]     wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              zero_wr_err
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_clr_busy;
  logic              r_zero_wr_err;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_idle;
  logic              w_wr_ok_a;
  logic              w_wr_ok_b;
  logic              w_zero_hit;

  // Address lies inside the bank (only matters for non-power-of-2 sizes).
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < CW'(NUM_REGS);
  endfunction

  // Address is the hardwired-zero register.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Read mux: range and zero rules first, then bypass (B over A), then storage.
  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (in_range(a) && !is_zero(a)) begin
      if ((BYPASS != 0) && w_idle && we_b && (wr_addr_b == a)) begin
        v = wr_data_b;
      end else if ((BYPASS != 0) && w_idle && we_a && (wr_addr_a == a)) begin
        v = wr_data_a;
      end else begin
        v = r_regs[a];
      end
    end
    return v;
  endfunction

  // Write qualification; both ports are frozen while a sweep runs.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_wr_ok_a  = w_idle && we_a && in_range(wr_addr_a) && !is_zero(wr_addr_a);
    w_wr_ok_b  = w_idle && we_b && in_range(wr_addr_b) && !is_zero(wr_addr_b);
    w_zero_hit = w_idle && (ZERO_REG != 0) &&
                 ((we_a && (wr_addr_a == '0)) || (we_b && (wr_addr_b == '0)));
  end

  always_comb begin
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
  end

  // Storage: sweep clears one entry per cycle; otherwise A then B, so B wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_regs <= '{default: '0};
    end else if (r_state == ST_CLEAR) begin
      r_regs[r_cnt[AW-1:0]] <= '0;
    end else begin
      if (w_wr_ok_a) r_regs[wr_addr_a] <= wr_data_a;
      if (w_wr_ok_b) r_regs[wr_addr_b] <= wr_data_b;
    end
  end

  // Clear engine and registered status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_clr_busy    <= 1'b0;
      r_zero_wr_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_zero_wr_err <= w_zero_hit;
          if (clr_req) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_zero_wr_err <= 1'b0;
          r_cnt         <= r_cnt + CW'(1);
          // Clearing the last index ends the sweep in the same cycle.
          if (r_cnt == CW'(NUM_REGS - 1)) begin
            r_state    <= ST_IDLE;
            r_clr_busy <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clr_busy    = r_clr_busy;
  assign zero_wr_err = r_zero_wr_err;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances share stimulus:
// u_dut1 uses the defaults (32 regs, zero register, bypass) and u_dut2 uses
// 24 regs with no zero register and no bypass, so out-of-range addresses exist.
module tb_regfile_mp;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        we_a, we_b, clr_req;
  logic [4:0]  wr_addr_a, wr_addr_b;
  logic [31:0] wr_data_a, wr_data_b;

  logic [31:0] d1_rd1, d1_rd2, d2_rd1, d2_rd2;
  logic        d1_busy, d1_zerr, d2_busy, d2_zerr;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut1 (
    .clock(clk), .reset(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_rd1), .rd_data2(d1_rd2),
    .we_a(we_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .we_b(we_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .clr_req(clr_req), .clr_busy(d1_busy), .zero_wr_err(d1_zerr)
  );

  regfile_mp #(.DATA_W(32), .NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) u_dut2 (
    .clock(clk), .reset(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d2_rd1), .rd_data2(d2_rd2),
    .we_a(we_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .we_b(we_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .clr_req(clr_req), .clr_busy(d2_busy), .zero_wr_err(d2_zerr)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_reads(input string tag, input logic [31:0] e11, input logic [31:0] e12,
                           input logic [31:0] e21, input logic [31:0] e22);
    push({tag, ".d1_rd1"}, e11);
    push({tag, ".d1_rd2"}, e12);
    push({tag, ".d2_rd1"}, e21);
    push({tag, ".d2_rd2"}, e22);
  endtask

  task automatic obs_reads();
    pop_chk(d1_rd1);
    pop_chk(d1_rd2);
    pop_chk(d2_rd1);
    pop_chk(d2_rd2);
  endtask

  task automatic exp_flags(input string tag, input logic b1, input logic z1,
                           input logic b2, input logic z2);
    push({tag, ".d1_busy"}, 32'(b1));
    push({tag, ".d1_zerr"}, 32'(z1));
    push({tag, ".d2_busy"}, 32'(b2));
    push({tag, ".d2_zerr"}, 32'(z2));
  endtask

  task automatic obs_flags();
    pop_chk(32'(d1_busy));
    pop_chk(32'(d1_zerr));
    pop_chk(32'(d2_busy));
    pop_chk(32'(d2_zerr));
  endtask

  task automatic idle();
    we_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    we_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    clr_req = 1'b0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic fill(input int first);
    for (int i = first; i < 32; i++) begin
      next_cyc();
      idle();
      we_a = 1'b1; wr_addr_a = 5'(i); wr_data_a = 32'(i + 1);
    end
    next_cyc();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr1 = '0;
    rd_addr2 = '0;

    // Reset state
    next_cyc();
    next_cyc();
    exp_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 obs_flags();
    next_cyc();
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      next_cyc();
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      exp_reads($sformatf("rst_rd%0d", a), '0, '0, '0, '0);
      #1 obs_reads();
    end
    exp_flags("rst_post", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 obs_flags();

    // Both ports write address 5: B wins, bypassed same cycle on dut1 only
    next_cyc();
    we_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'h1111_1111;
    we_b = 1'b1; wr_addr_b = 5'd5; wr_data_b = 32'h2222_2222;
    rd_addr1 = 5'd5; rd_addr2 = 5'd4;
    exp_reads("dual_same", 32'h2222_2222, '0, '0, '0);
    #1 obs_reads();
    next_cyc();
    idle();
    exp_reads("dual_next", 32'h2222_2222, '0, 32'h2222_2222, '0);
    #1 obs_reads();

    // Distinct addresses: each read port picks up its own bypassed write
    next_cyc();
    we_a = 1'b1; wr_addr_a = 5'd6; wr_data_a = 32'hA5A5_A5A5;
    we_b = 1'b1; wr_addr_b = 5'd7; wr_data_b = 32'h5A5A_5A5A;
    rd_addr1 = 5'd6; rd_addr2 = 5'd7;
    exp_reads("bp_ab", 32'hA5A5_A5A5, 32'h5A5A_5A5A, '0, '0);
    #1 obs_reads();
    next_cyc();
    idle();
    exp_reads("bp_ab_next", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    #1 obs_reads();

    // Overwrite address 3: no-bypass instance shows the old value first
    next_cyc();
    we_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h1234_5678;
    next_cyc();
    idle();
    we_b = 1'b1; wr_addr_b = 5'd3; wr_data_b = 32'hDEAD_BEEF;
    rd_addr1 = 5'd3; rd_addr2 = 5'd3;
    exp_reads("nobp_same", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678);
    #1 obs_reads();
    next_cyc();
    idle();
    exp_reads("nobp_next", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    #1 obs_reads();

    // Write to register 0
    next_cyc();
    we_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFF_FFFF;
    rd_addr1 = 5'd0; rd_addr2 = 5'd5;
    exp_reads("zw_same", '0, 32'h2222_2222, '0, 32'h2222_2222);
    exp_flags("zw_same", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    next_cyc();
    idle();
    exp_reads("zw_next", '0, 32'h2222_2222, 32'hFFFF_FFFF, 32'h2222_2222);
    exp_flags("zw_next", 1'b0, 1'b1, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    next_cyc();
    exp_flags("zw_end", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 obs_flags();

    // Both ports write register 0: a single pulse
    next_cyc();
    we_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'h0000_0001;
    we_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 32'h0000_0002;
    exp_reads("zw2_same", '0, 32'h2222_2222, 32'hFFFF_FFFF, 32'h2222_2222);
    exp_flags("zw2_same", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    next_cyc();
    idle();
    exp_reads("zw2_next", '0, 32'h2222_2222, 32'h0000_0002, 32'h2222_2222);
    exp_flags("zw2_next", 1'b0, 1'b1, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    next_cyc();
    exp_flags("zw2_end", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 obs_flags();

    // Address 25 is out of range for the 24-entry instance
    next_cyc();
    we_a = 1'b1; wr_addr_a = 5'd25; wr_data_a = 32'hCAFE_F00D;
    rd_addr1 = 5'd25; rd_addr2 = 5'd0;
    exp_reads("oor_same", 32'hCAFE_F00D, '0, '0, 32'h0000_0002);
    #1 obs_reads();
    next_cyc();
    idle();
    exp_reads("oor_next", 32'hCAFE_F00D, '0, '0, 32'h0000_0002);
    #1 obs_reads();

    // Fill with index+1 and read back
    fill(0);
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(i);
      exp_reads($sformatf("fill%0d", i),
                (i == 0) ? 32'd0 : 32'(i + 1), (i == 0) ? 32'd0 : 32'(i + 1),
                (i < 24) ? 32'(i + 1) : 32'd0, (i < 24) ? 32'(i + 1) : 32'd0);
      #1 obs_reads();
      next_cyc();
    end

    // Start sweep; the write in the same cycle is still performed
    idle();
    clr_req = 1'b1;
    we_b = 1'b1; wr_addr_b = 5'd2; wr_data_b = 32'h0000_0077;
    rd_addr1 = 5'd2; rd_addr2 = 5'd31;
    exp_reads("clr_start", 32'h0000_0077, 32'd32, 32'd3, '0);
    exp_flags("clr_start", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    for (int j = 0; j < 32; j++) begin
      next_cyc();
      idle();
      we_a = 1'b1; wr_addr_a = 5'd31; wr_data_a = 32'h0000_0BAD;
      if (j < 24) begin
        we_b = 1'b1; wr_addr_b = 5'd0; wr_data_b = 32'h0000_BEEF;
      end
      clr_req = (j == 3);
      rd_addr1 = 5'(j);
      rd_addr2 = (j == 0) ? 5'd31 : 5'(j - 1);
      exp_reads($sformatf("sweep%0d", j),
                (j == 0) ? 32'd0 : ((j == 2) ? 32'h77 : 32'(j + 1)),
                (j == 0) ? 32'd32 : 32'd0,
                (j < 24) ? ((j == 2) ? 32'h77 : 32'(j + 1)) : 32'd0,
                32'd0);
      exp_flags($sformatf("sweep%0d", j), 1'b1, 1'b0, (j < 24), 1'b0);
      #1 begin obs_reads(); obs_flags(); end
    end
    next_cyc();
    idle();
    exp_flags("sweep_done", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 obs_flags();
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      exp_reads($sformatf("post_clr%0d", a), '0, '0, '0, '0);
      #1 obs_reads();
      next_cyc();
    end

    // Reset during sweep cycle 10 with registers populated
    fill(1);
    clr_req = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      next_cyc();
      idle();
    end
    rd_addr1 = 5'd20; rd_addr2 = 5'd12;
    exp_reads("pre_abort", 32'd21, 32'd13, 32'd21, 32'd13);
    exp_flags("pre_abort", 1'b1, 1'b0, 1'b1, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    rst_n = 1'b0;
    exp_reads("abort", '0, '0, '0, '0);
    exp_flags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    next_cyc();
    rst_n = 1'b1;
    we_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h7777_7777;
    rd_addr1 = 5'd7; rd_addr2 = 5'd20;
    exp_reads("rel_wr", 32'h7777_7777, '0, '0, '0);
    exp_flags("rel_wr", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end
    next_cyc();
    idle();
    exp_reads("rel_next", 32'h7777_7777, '0, 32'h7777_7777, '0);
    exp_flags("rel_next", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 begin obs_reads(); obs_flags(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
